// File: rtl/rd_wait_capture_if.sv
// Sequencer-facing strobes plus the captured-word valid/ready port of rd_wait_capture.
// master = sequencer/consumer side, slave = rd_wait_capture.
interface rd_wait_capture_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          rd;
    logic          ds;
    logic [DW-1:0] mem_data;
    logic          ws;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          err;

    modport master (
        output rd, ds, mem_data, out_ready,
        input  ws, out_data, out_valid, level, err
    );

    modport slave (
        input  rd, ds, mem_data, out_ready,
        output ws, out_data, out_valid, level, err
    );
endinterface

// File: rtl/rd_wait_capture.sv
// Inserts WAIT_CYCLES ws retries per read burst and captures mem_data into a DEPTH FIFO; RD_WAIT_CAPTURE_PCHK_EN adds a sticky protocol checker on err.
// Latency: release DLY at edge N -> out_valid after edge N+1 (empty FIFO).
// Backpressure: out_valid/out_ready pop; a full FIFO holds the sequencer in ws=1 until a slot frees.
module rd_wait_capture #(
    parameter int WAIT_CYCLES = 2,
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int AW          = 2
) (
    input  logic            clk,
    input  logic            reset,
    rd_wait_capture_if.slave bus
);
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);

    logic          ph;
    logic          ws_q;
    logic [7:0]    cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [DW-1:0] mem [DEPTH];

    logic          read_cyc;
    logic          dly_cyc;
    logic          push;
    logic          pop;
    logic [AW:0]   level_nxt;
    logic [AW-1:0] rd_ptr_nxt;

    always_comb begin
        read_cyc   = bus.rd & ~ph;
        dly_cyc    = bus.rd & ph;
        push       = dly_cyc & ~ws_q;
        pop        = out_valid_q & bus.out_ready;
        level_nxt  = level_q - (AW+1)'(pop);
        rd_ptr_nxt = rd_ptr + AW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph          <= 1'b0;
            ws_q        <= 1'b0;
            cnt         <= WAIT_INIT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            ph   <= read_cyc;
            // Level after this cycle's pop: a full FIFO must not accept the coming DLY push.
            ws_q <= read_cyc & ((cnt != 8'd0) | (level_nxt == FULL));

            if (bus.ds)
                cnt <= WAIT_INIT;
            else if (dly_cyc & ws_q & (cnt != 8'd0))
                cnt <= cnt - 8'd1;

            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_ptr_nxt;
            level_q <= level_nxt + (AW+1)'(push);

            // Only words already stored before this edge become visible, so a
            // fresh push shows up one cycle later and never reads a word in flight.
            out_valid_q <= (level_nxt != '0);
            if (level_nxt != '0)
                out_data_q <= mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.mem_data;
    end

    assign bus.ws        = ws_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.level     = level_q;

`ifdef RD_WAIT_CAPTURE_PCHK_EN
    logic prev_rel;
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_rel <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_rel <= push;
            if ((bus.ds & ~prev_rel) | (~bus.rd & ph) | (bus.rd & bus.ds))
                err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_rd_wait_capture.sv
// Directed bench for rd_wait_capture with a scoreboard of captured words checked on every pop.
module tb_rd_wait_capture;
`ifdef RD_WAIT_CAPTURE_PCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    rd_wait_capture_if #(.DW(8), .AW(2)) bus ();

    rd_wait_capture #(.WAIT_CYCLES(2), .DW(8), .DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [7:0] exp_q [$];
    int vcnt;
    int peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every pop must match the oldest captured word.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) vcnt++;
            if (int'(bus.level) > peak) peak = int'(bus.level);
            if (bus.out_valid && bus.out_ready) begin
                n_asserts++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow: observed pop of %0h with %0d pending, expected >0 pending",
                           bus.out_data, exp_q.size());
                end
                if (exp_q.size() != 0)
                    chk("pop_data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // One sequencer burst: READ/DLY pairs until release or max_dly wait visits.
    task automatic burst(input logic [7:0] d, input int max_dly, input bit rdy_rel,
                         output bit rel, output int nw);
        rel = 1'b0;
        nw  = 0;
        bus.mem_data = d;
        while (!rel && nw < max_dly) begin
            bus.rd = 1'b1;
            bus.ds = 1'b0;
            tick();
            if (!bus.ws) begin
                rel = 1'b1;
                exp_q.push_back(d);
                if (rdy_rel) bus.out_ready = 1'b1;
                tick();
                if (rdy_rel) bus.out_ready = 1'b0;
                bus.rd = 1'b0;
                bus.ds = 1'b1;
                tick();
                bus.ds = 1'b0;
            end else begin
                nw++;
                tick();
            end
        end
    endtask

    task automatic drain(input int budget);
        int i = 0;
        bus.out_ready = 1'b1;
        while ((bus.level != 3'd0 || bus.out_valid) && i < budget) begin
            tick();
            i++;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rel;
        int nw;

        // 1. reset state
        reset = 1'b1;
        bus.rd = 1'b0;
        bus.ds = 1'b0;
        bus.mem_data = 8'h00;
        bus.out_ready = 1'b0;
        vcnt = 0;
        peak = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ws",    {31'd0, bus.ws}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_level", {29'd0, bus.level}, 32'd0);
        chk("rst_err",   {31'd0, bus.err}, 32'd0);

        // 2. single burst, consumer ready
        bus.out_ready = 1'b1;
        vcnt = 0;
        peak = 0;
        burst(8'hA5, 10, 1'b0, rel, nw);
        chk("t2_rel",   {31'd0, rel}, 32'd1);
        chk("t2_waits", nw, 32'd2);
        repeat (4) tick();
        chk("t2_vcycles", vcnt, 32'd1);
        chk("t2_peak",    peak, 32'd1);
        chk("t2_level",   {29'd0, bus.level}, 32'd0);
        chk("t2_sb",      exp_q.size(), 32'd0);

        // 3. fill FIFO, fifth burst held until consumer frees a slot
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            burst(8'(k), 10, 1'b0, rel, nw);
            chk("t3_rel", {31'd0, rel}, 32'd1);
            chk("t3_waits", nw, 32'd2);
        end
        chk("t3_level4", {29'd0, bus.level}, 32'd4);
        chk("t3_head",   {24'd0, bus.out_data}, 32'h01);
        burst(8'h05, 6, 1'b0, rel, nw);
        chk("t3_hold_rel",  {31'd0, rel}, 32'd0);
        chk("t3_hold_dly",  nw, 32'd6);
        chk("t3_hold_lvl",  {29'd0, bus.level}, 32'd4);
        bus.out_ready = 1'b1;
        burst(8'h05, 4, 1'b0, rel, nw);
        chk("t3_rel5",   {31'd0, rel}, 32'd1);
        chk("t3_waits5", nw, 32'd0);
        drain(20);
        chk("t3_drained", {29'd0, bus.level}, 32'd0);
        chk("t3_sb",      exp_q.size(), 32'd0);

        // 4. push and pop in the same cycle at level 2
        bus.out_ready = 1'b0;
        burst(8'h11, 10, 1'b0, rel, nw);
        burst(8'h22, 10, 1'b0, rel, nw);
        tick();
        chk("t4_level2", {29'd0, bus.level}, 32'd2);
        burst(8'h33, 10, 1'b1, rel, nw);
        chk("t4_rel",    {31'd0, rel}, 32'd1);
        chk("t4_level",  {29'd0, bus.level}, 32'd2);
        chk("t4_head",   {24'd0, bus.out_data}, 32'h22);
        drain(20);
        chk("t4_sb", exp_q.size(), 32'd0);
        chk("t4_err", {31'd0, bus.err}, 32'd0);

        // 5. reset during the release DLY cycle
        bus.out_ready = 1'b0;
        burst(8'hEE, 2, 1'b0, rel, nw);
        chk("t5_pre_waits", nw, 32'd2);
        bus.rd = 1'b1;
        tick();
        chk("t5_release_ws", {31'd0, bus.ws}, 32'd0);
        bus.mem_data = 8'hEE;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_level", {29'd0, bus.level}, 32'd0);
        tick();
        reset = 1'b0;
        bus.rd = 1'b0;
        tick();
        chk("t5_ws",    {31'd0, bus.ws}, 32'd0);
        chk("t5_level", {29'd0, bus.level}, 32'd0);
        chk("t5_valid", {31'd0, bus.out_valid}, 32'd0);
        burst(8'h5A, 10, 1'b0, rel, nw);
        chk("t5_rel",   {31'd0, rel}, 32'd1);
        chk("t5_waits", nw, 32'd2);
        drain(20);
        chk("t5_sb", exp_q.size(), 32'd0);

        // 6. stray ds with rd idle
        bus.out_ready = 1'b0;
        chk("t6_err_pre", {31'd0, bus.err}, 32'd0);
        bus.ds = 1'b1;
        tick();
        bus.ds = 1'b0;
        tick();
        chk("t6_err", {31'd0, bus.err}, {31'd0, EXP_ERR});
        repeat (5) tick();
        chk("t6_err_sticky", {31'd0, bus.err}, {31'd0, EXP_ERR});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_err_rst", {31'd0, bus.err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
